vga_framebuffer: RTL and testbench
==================================

// Module: vga_framebuffer
// PURPOSE
//  Pixel source feeding the VGA output stage. Holds a 160x120 RGB332 framebuffer, each cell shown as a 4x4 block on 640x480.
//  Display side: takes the stage's x/y scan coordinates and returns registered 8-bit r/g/b.
//  Write side: game logic writes single cells; a clear FSM fills the whole buffer with one colour.
// PARAMETERS
//  FB_W      160  framebuffer width in cells (640 >> SCALE_SH)
//  FB_H      120  framebuffer height in cells (480 >> SCALE_SH)
//  SCALE_SH  2    log2 of cell-to-screen-pixel scale
//  BLANK_C   8'h00  RGB332 colour output outside the 640x480 active area
// PORTS
//  clk        in   1   system clock (2x pixel clock)
//  rst        in   1   asynchronous reset, active-low
//  x          in   10  scan column from the VGA stage, 0..799
//  y          in   10  scan row from the VGA stage, 0..524
//  r          out  8   red to the VGA stage
//  g          out  8   green to the VGA stage
//  b          out  8   blue to the VGA stage
//  wr_en      in   1   write strobe, one cell per clk
//  wr_x       in   8   write cell column
//  wr_y       in   7   write cell row
//  wr_data    in   8   write colour, RGB332 {r[2:0],g[2:0],b[1:0]}
//  clr_start  in   1   start-clear pulse
//  clr_color  in   8   fill colour, sampled with clr_start
//  busy       out  1   clear in progress
//  clr_done   out  1   one-clk pulse on the final clear write
// BEHAVIOUR
//  Interface: one clock, clk. rst is asynchronous and active-low. No other clock domain; x/y change every 2nd clk edge.
//  Reset: r=g=b=0, busy=0, clr_done=0, all pipeline regs 0, FSM=IDLE. Memory contents are not reset.
//  Memory: FB_W*FB_H x 8 bits (19200), linear addr = cy*160 + cx.
//  - Compute the multiply as (cy<<7)+(cy<<5).
//  - Memory is true dual-port: one display read port and one write port.
//  - A read and a write to the same addr in the same clk return the OLD data.
//  Display pipeline, 3 register stages:
//  - S1 samples x,y. Cell coords are x>>SCALE_SH and y>>SCALE_SH. Registers addr and active = (x<640)&(y<480).
//  - S2 is the synchronous memory read; active is delayed alongside it.
//  - S3 is the output register. Colour is the RAM data if active, else BLANK_C.
//  - S3 expansion: r={c[7:5],c[7:5],c[7:6]}, g={c[4:2],c[4:2],c[4:3]}, b={c[1:0],c[1:0],c[1:0],c[1:0]}.
//  - Latency: r/g/b for a given x/y are valid 3 clk edges after that x/y appears, then hold 2 clk.
//  - The VGA stage therefore captures them one pixel late. Its one-pixel sync delay absorbs this.
//  - Addr is never formed from an out-of-range x/y: inactive coords force addr 0.
//  Write port (IDLE only):
//  - wr_en with wr_x<FB_W and wr_y<FB_H writes wr_data the next clk edge.
//  - Out-of-range coords are ignored silently.
//  Clear FSM, states IDLE and CLEAR:
//  - IDLE->CLEAR on clr_start. Latch clr_color; cnt=0; busy=1 from the next edge.
//  - CLEAR writes the colour to addr cnt each clk, cnt++. Ignores wr_en and clr_start.
//  - Last write at cnt=FB_W*FB_H-1: clr_done=1 that same cycle, then ->IDLE with busy=0 next edge.
//  - A clear takes 19200 clk.
//  - The display keeps reading during CLEAR; a partially cleared frame is acceptable.
//  - clr_start and wr_en together in IDLE: the clear wins and the write is dropped.
//  - clr_start held high: the clear is re-armed only after returning to IDLE.
//  Reset mid-clear: immediate abort, busy=0, FSM=IDLE. Memory is left partially cleared.
// TESTING
//  1. Reset with x=y=0, then release -> r=g=b=0, busy=0, clr_done=0 until the first S3 update.
//  2. Write (5,3)=8'hE0, then scan x=20..23, y=12..15 -> r=8'hFF,g=0,b=0 for all 16 pixels, 3 clk after each x/y; (4,3) unchanged.
//  3. Scan x=640 and y=480 over cells holding 8'hFF -> r=g=b=BLANK_C-expanded 0; no addr>19199 issued.
//  4. clr_start with clr_color=8'h1C -> busy high for 19200 clk; clr_done exactly once at the end; full scan gives g=8'hFF, r=b=0.
//  5. wr_en to (0,0) during CLEAR, and wr_en with clr_start in IDLE -> both writes dropped; write at wr_x=160 -> no memory change.
//  6. Assert rst at cnt=1000 of a clear, then release -> busy=0, idle; cells 0..999 hold the clear colour, cell 1000 is old data.

Source files
------------

// File: rtl/vga_framebuffer.sv
// 160x120 RGB332 framebuffer scaled 4x onto 640x480, with a
// 3-stage display read pipeline, a cell write port and a clear FSM.
module vga_framebuffer #(
  parameter int         FB_W     = 160,
  parameter int         FB_H     = 120,
  parameter int         SCALE_SH = 2,
  parameter logic [7:0] BLANK_C  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [7:0] r,
  output logic [7:0] g,
  output logic [7:0] b,
  input  logic       wr_en,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  logic [7:0] wr_data,
  input  logic       clr_start,
  input  logic [7:0] clr_color,
  output logic       busy,
  output logic       clr_done
);

  localparam int NPIX = FB_W * FB_H;
  localparam int ACT_W = FB_W << SCALE_SH;
  localparam int ACT_H = FB_H << SCALE_SH;
  localparam logic [14:0] LAST = 15'(NPIX - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  logic [7:0]  mem [NPIX];

  state_t      state, state_n;
  logic [14:0] cnt;
  logic [7:0]  color;

  logic [14:0] cx, cy, rd_addr;
  logic        act;
  logic [14:0] addr1;
  logic        act1, act2;
  logic [7:0]  rdata, c;

  logic [14:0] wx, wy;
  logic        wr_ok;
  logic        we;
  logic [14:0] waddr;
  logic [7:0]  wdata;

  // cy*160 as two shifts; inactive coords force address 0
  always_comb begin
    cx      = 15'(x >> SCALE_SH);
    cy      = 15'(y >> SCALE_SH);
    act     = (x < 10'(ACT_W)) && (y < 10'(ACT_H));
    rd_addr = act ? (cy << 7) + (cy << 5) + cx : '0;
  end

  always_comb begin
    wx    = 15'(wr_x);
    wy    = 15'(wr_y);
    wr_ok = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));
  end

  always_comb begin
    state_n  = state;
    we       = 1'b0;
    waddr    = (wy << 7) + (wy << 5) + wx;
    wdata    = wr_data;
    clr_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_start) state_n = CLEAR;
        else if (wr_en && wr_ok) we = 1'b1;
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = cnt;
        wdata = color;
        if (cnt == LAST) begin
          clr_done = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == CLEAR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      color <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && clr_start) begin
        cnt   <= '0;
        color <= clr_color;
      end else if (state == CLEAR) begin
        cnt <= cnt + 15'd1;
      end
    end
  end

  // unreset storage; read-during-write returns old data
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign c = act2 ? rdata : BLANK_C;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr1 <= '0;
      act1  <= 1'b0;
      rdata <= '0;
      act2  <= 1'b0;
      r     <= '0;
      g     <= '0;
      b     <= '0;
    end else begin
      addr1 <= rd_addr;
      act1  <= act;
      rdata <= mem[addr1];
      act2  <= act1;
      r     <= {c[7:5], c[7:5], c[7:6]};
      g     <= {c[4:2], c[4:2], c[4:3]};
      b     <= {c[1:0], c[1:0], c[1:0], c[1:0]};
    end
  end

endmodule

// File: tb/tb_vga_framebuffer.sv
// Directed bench for vga_framebuffer: display pipeline,
// cell writes, clear FSM and reset during a clear.
module tb_vga_framebuffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x, y;
  logic [7:0] r, g, b;
  logic       wr_en;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [7:0] wr_data;
  logic       clr_start;
  logic [7:0] clr_color;
  logic       busy, clr_done;

  int checks = 0;
  int failures = 0;

  vga_framebuffer dut (
    .clk(clk), .rst(rst), .x(x), .y(y),
    .r(r), .g(g), .b(b),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .clr_start(clr_start), .clr_color(clr_color),
    .busy(busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_cell(input int cx, input int cy, input logic [7:0] d);
    wr_en = 1'b1;
    wr_x = 8'(cx);
    wr_y = 7'(cy);
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic show(input int px, input int py);
    x = 10'(px);
    y = 10'(py);
    repeat (3) tick();
  endtask

  task automatic chk_cell(input string tag, input int cx, input int cy,
                          input logic [23:0] exp);
    show(cx * 4, cy * 4);
    chk(tag, {8'h0, r, g, b}, {8'h0, exp});
  endtask

  int n, dn, dn_at;

  initial begin
    rst = 1'b0;
    x = '0; y = '0;
    wr_en = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    clr_start = 1'b0; clr_color = '0;
    repeat (3) tick();
    chk("rst_rgb", {8'h0, r, g, b}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, clr_done}, 32'h0);
    rst = 1'b1;
    #1;
    chk("rel_rgb", {8'h0, r, g, b}, 32'h0);
    tick();
    chk("rel_rgb_1", {8'h0, r, g, b}, 32'h0);
    tick();
    chk("rel_rgb_2", {8'h0, r, g, b}, 32'h0);
    chk("rel_busy", {31'h0, busy}, 32'h0);

    wr_cell(4, 3, 8'h03);
    wr_cell(5, 3, 8'hE0);
    show(16, 12);
    chk("nb_blue", {8'h0, r, g, b}, 32'h0000FF);
    x = 10'd20;
    tick();
    tick();
    chk("lat_2", {8'h0, r, g, b}, 32'h0000FF);
    tick();
    chk("lat_3", {8'h0, r, g, b}, 32'hFF0000);
    for (int j = 12; j < 16; j++)
      for (int i = 20; i < 24; i++) begin
        show(i, j);
        chk($sformatf("red_%0d_%0d", i, j), {8'h0, r, g, b}, 32'hFF0000);
      end
    chk_cell("left_kept", 4, 3, 24'h0000FF);

    wr_cell(0, 0, 8'hFF);
    wr_cell(159, 0, 8'hFF);
    wr_cell(0, 119, 8'hFF);
    chk_cell("white", 0, 0, 24'hFFFFFF);
    show(640, 0);
    chk("blank_x640", {8'h0, r, g, b}, 32'h0);
    show(0, 480);
    chk("blank_y480", {8'h0, r, g, b}, 32'h0);
    show(799, 524);
    chk("blank_far", {8'h0, r, g, b}, 32'h0);
    show(636, 0);
    chk("edge_x636", {8'h0, r, g, b}, 32'hFFFFFF);
    show(0, 479);
    chk("edge_y479", {8'h0, r, g, b}, 32'hFFFFFF);

    clr_color = 8'h1C;
    clr_start = 1'b1;
    #1;
    chk("pre_busy", {31'h0, busy}, 32'h0);
    tick();
    clr_start = 1'b0;
    n = 0; dn = 0; dn_at = -1;
    while (busy && n < 25000) begin
      if (clr_done) begin
        dn++;
        dn_at = n;
      end
      if (n == 100) begin
        wr_en = 1'b1; wr_x = '0; wr_y = '0; wr_data = 8'hE0;
      end
      if (n == 101) wr_en = 1'b0;
      if (n == 200) clr_start = 1'b1;
      if (n == 201) clr_start = 1'b0;
      n++;
      tick();
    end
    chk("clr_len", n, 19200);
    chk("clr_done_cnt", dn, 1);
    chk("clr_done_at", dn_at, 19199);
    chk("post_busy", {31'h0, busy}, 32'h0);
    chk("post_done", {31'h0, clr_done}, 32'h0);
    chk_cell("clr_00", 0, 0, 24'h00FF00);
    chk_cell("clr_5_3", 5, 3, 24'h00FF00);
    chk_cell("clr_80_60", 80, 60, 24'h00FF00);
    chk_cell("clr_159_119", 159, 119, 24'h00FF00);

    wr_cell(160, 0, 8'hE0);
    wr_cell(0, 120, 8'hE0);
    chk_cell("oob_x", 0, 1, 24'h00FF00);
    chk_cell("oob_last", 159, 119, 24'h00FF00);

    clr_color = 8'h03;
    clr_start = 1'b1;
    wr_en = 1'b1; wr_x = 8'd0; wr_y = 7'd10; wr_data = 8'hE0;
    tick();
    clr_start = 1'b0;
    wr_en = 1'b0;
    chk("clr2_busy", {31'h0, busy}, 32'h1);
    repeat (1000) tick();
    rst = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_done", {31'h0, clr_done}, 32'h0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("idle_busy", {31'h0, busy}, 32'h0);
    chk_cell("part_0", 0, 0, 24'h0000FF);
    chk_cell("part_999", 39, 6, 24'h0000FF);
    chk_cell("part_1000", 40, 6, 24'h00FF00);
    chk_cell("drop_wr", 0, 10, 24'h00FF00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
